// File: rtl/number_uart_reporter_if.sv
// Bus between the stopwatch counter and the UART reporter: the digit value
// and trigger flow in, and the serial line plus frame status flow out.
interface number_uart_reporter_if #(
  parameter int NUMBER_OF_DIGITS = 4
);
  logic [NUMBER_OF_DIGITS*4-1:0] number;
  logic                          trigger;
  logic                          usb_tx;
  logic                          busy;
  logic                          frame_done;

  modport master (
    output number, trigger,
    input  usb_tx, busy, frame_done
  );

  modport slave (
    input  number, trigger,
    output usb_tx, busy, frame_done
  );
endinterface

// File: rtl/number_uart_reporter.sv
// Sends the packed hex digits as ASCII followed by CR LF over UART 8N1, on a periodic tick or a trigger.
// Optional macro NUMBER_UART_REPORTER_CHANGE_ONLY_EN: periodic ticks report only a changed value.
module number_uart_reporter #(
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int BAUD_RATE                   = 115_200,
  parameter int REPORT_RATE_IN_HZ           = 10,
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  number_uart_reporter_if.slave bus
);

  localparam int CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int TICK_PERIOD  = BOARD_CLOCK_FREQUENCY_IN_HZ / REPORT_RATE_IN_HZ;
  localparam int NUM_W        = NUMBER_OF_DIGITS * NUMBER_OF_BITS_PER_DIGIT;
  localparam int NUM_BYTES    = NUMBER_OF_DIGITS + 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int TICK_W       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam int BYTE_W       = $clog2(NUM_BYTES);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);
  localparam logic [BYTE_W-1:0] BYTE_CR   = BYTE_W'(NUMBER_OF_DIGITS);
  localparam logic [BYTE_W-1:0] BYTE_LF   = BYTE_W'(NUMBER_OF_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e            state_q,    state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0]  clk_cnt_q,  clk_cnt_d;
  logic [2:0]        bit_idx_q,  bit_idx_d;
  logic [BYTE_W-1:0] byte_idx_q, byte_idx_d;
  logic [NUM_W-1:0]  shadow_q,   shadow_d;
  logic              pending_q,  pending_d;
  logic              tx_q,       tx_d;
  logic              busy_q;
  logic              frame_done_q;

  logic              tick;
  logic              request;
  logic              bit_end;
  logic [BYTE_W-1:0] digit_idx;
  logic [NUM_W-1:0]  shifted;
  logic [7:0]        tx_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h37 + {4'h0, d});
  endfunction

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign bit_end = (clk_cnt_q == BIT_LAST);

`ifdef NUMBER_UART_REPORTER_CHANGE_ONLY_EN
  // shadow_q holds the last value sent (or in flight), so it doubles as the change reference.
  assign request = bus.trigger | (tick & (bus.number != shadow_q));
`else
  assign request = bus.trigger | tick;
`endif

  // Byte k < NUMBER_OF_DIGITS carries digit NUMBER_OF_DIGITS-1-k, most significant first.
  assign digit_idx = BYTE_CR - 1'b1 - byte_idx_q;
  assign shifted   = shadow_q >> (NUMBER_OF_BITS_PER_DIGIT * int'(digit_idx));
  assign tx_byte   = (byte_idx_q == BYTE_CR) ? 8'h0D :
                     (byte_idx_q == BYTE_LF) ? 8'h0A : hex_ascii(shifted[3:0]);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    tx_d       = 1'b1;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (request || pending_q) begin
          shadow_d   = bus.number;
          pending_d  = 1'b0;
          byte_idx_d = '0;
          clk_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = tx_byte[bit_idx_q];
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (byte_idx_q != BYTE_LF) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && request) pending_d = 1'b1;
  end

  // Line, busy and frame_done trail the state by one cycle; frame_done marks the
  // first cycle busy drops after a frame.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments; reset here is synchronous to clk.
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      byte_idx_q   <= byte_idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      tx_q         <= tx_d;
      busy_q       <= (state_q != IDLE);
      frame_done_q <= (state_q == IDLE) && busy_q;
    end
  end

  assign bus.usb_tx     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule
